cordic_z_vec: RTL and testbench

//  Bit-serial CORDIC angle accumulator for vectoring mode. The rotation-mode z path consumes an angle and emits directions; this block is its inverse.
//  It starts from a known angle and adds or subtracts atan(2^-k) per iteration, as directed by the y path.
//  The angle is built LSB-first through a 1-bit full adder. The finished angle is presented in parallel with a valid pulse.

---
 rtl/cordic_z_vec.sv | 157 +++++++++++++++
 tb/tb_cordic_z_vec.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cordic_z_vec.sv
// cordic_z_vec: bit-serial CORDIC vectoring-mode angle accumulator (LSB-first, 1-bit full adder).
// Define CORDIC_Z_QUAD_EN to seed the angle with +pi/2 when quad_in is high at start.
module cordic_z_vec #(
    parameter int WIDTH = 16,
    parameter int ITERS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dir_valid,
    input  logic             dir_in,
    input  logic             quad_in,
    output logic             dir_req,
    output logic             z_bit,
    output logic [3:0]       iter,
    output logic             busy,
    output logic [WIDTH-1:0] z_out,
    output logic             z_valid
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_DIR = 2'd1,
        SHIFT    = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] z;
    logic [WIDTH-1:0] z_seed;
    logic [CW-1:0]    bit_cnt;
    logic             carry;
    logic             dir;
    logic [15:0]      rom_word;
    logic             r_bit;
    logic             sum;
    logic             carry_next;
    logic             last_bit;
    logic             last_iter;

    function automatic logic [15:0] atan_rom(input logic [3:0] k);
        case (k)
            4'd0:    atan_rom = 16'd8192;
            4'd1:    atan_rom = 16'd4836;
            4'd2:    atan_rom = 16'd2555;
            4'd3:    atan_rom = 16'd1297;
            4'd4:    atan_rom = 16'd651;
            4'd5:    atan_rom = 16'd326;
            4'd6:    atan_rom = 16'd163;
            4'd7:    atan_rom = 16'd81;
            4'd8:    atan_rom = 16'd41;
            4'd9:    atan_rom = 16'd20;
            4'd10:   atan_rom = 16'd10;
            4'd11:   atan_rom = 16'd5;
            4'd12:   atan_rom = 16'd3;
            4'd13:   atan_rom = 16'd1;
            4'd14:   atan_rom = 16'd1;
            default: atan_rom = 16'd0;
        endcase
    endfunction

`ifdef CORDIC_Z_QUAD_EN
    assign z_seed = quad_in ? (WIDTH'(1) << (WIDTH - 2)) : '0;
`else
    logic unused_quad;
    assign unused_quad = quad_in;
    assign z_seed      = '0;
`endif

    // Subtraction is z + ~rom + 1: the +1 comes from seeding carry with 1.
    assign rom_word   = atan_rom(iter);
    assign r_bit      = rom_word[bit_cnt] ^ ~dir;
    assign sum        = z[0] ^ r_bit ^ carry;
    assign carry_next = (z[0] & r_bit) | (z[0] & carry) | (r_bit & carry);
    assign last_bit   = (bit_cnt == CW'(WIDTH - 1));
    assign last_iter  = (iter == 4'(ITERS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Direction handshake: one direction is consumed on a rising edge where
    // dir_req and dir_valid are both high; dir_valid low while dir_req is high stalls.
    always_comb begin
        state_next = state;
        dir_req    = 1'b0;
        busy       = 1'b0;
        z_valid    = 1'b0;
        z_bit      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = WAIT_DIR;
            end
            WAIT_DIR: begin
                dir_req = 1'b1;
                busy    = 1'b1;
                if (dir_valid) state_next = SHIFT;
            end
            SHIFT: begin
                busy  = 1'b1;
                z_bit = sum;
                if (last_bit) state_next = last_iter ? DONE : WAIT_DIR;
            end
            DONE: begin
                z_valid    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            z       <= '0;
            z_out   <= '0;
            bit_cnt <= '0;
            carry   <= 1'b0;
            dir     <= 1'b0;
            iter    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        iter <= '0;
                        z    <= z_seed;
                    end
                end
                WAIT_DIR: begin
                    if (dir_valid) begin
                        dir     <= dir_in;
                        carry   <= ~dir_in;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    z       <= {sum, z[WIDTH-1:1]};
                    carry   <= carry_next;
                    bit_cnt <= bit_cnt + 1'b1;
                    // z_out is loaded as DONE is entered so it is valid alongside z_valid.
                    if (last_bit) begin
                        if (last_iter) z_out <= {sum, z[WIDTH-1:1]};
                        else           iter  <= iter + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_z_vec.sv
// tb_cordic_z_vec: vector table plus random jobs against an integer angle-sum model.
// The quadrant-seed expectation follows CORDIC_Z_QUAD_EN when the bench is built with it.
module tb_cordic_z_vec;

    localparam int WIDTH = 16;
    localparam int ITERS = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             dir_valid;
    logic             dir_in;
    logic             quad_in;
    logic             dir_req;
    logic             z_bit;
    logic [3:0]       iter;
    logic             busy;
    logic [WIDTH-1:0] z_out;
    logic             z_valid;

    int checks;
    int errors;
    logic [WIDTH-1:0] exp_q[$];

    int atan_tab[16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0};

    typedef struct {
        logic [15:0] dirs;
        logic        quad;
        int          stall_iter;
        int          stall_len;
        logic [15:0] exp_z;
    } vec_t;

    cordic_z_vec #(.WIDTH(WIDTH), .ITERS(ITERS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dir_valid (dir_valid),
        .dir_in    (dir_in),
        .quad_in   (quad_in),
        .dir_req   (dir_req),
        .z_bit     (z_bit),
        .iter      (iter),
        .busy      (busy),
        .z_out     (z_out),
        .z_valid   (z_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Angle after the first 'upto' iterations: seed plus/minus the atan table, mod 2^16.
    function automatic logic [15:0] model_z(input logic [15:0] dirs, input logic quad, input int upto);
        int acc;
        logic unused_q;
        acc = 0;
        unused_q = quad;
`ifdef CORDIC_Z_QUAD_EN
        if (quad) acc = 16384;
`endif
        for (int i = 0; i < upto; i++) acc += dirs[i] ? atan_tab[i] : -atan_tab[i];
        return acc[15:0];
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " dir_req"}, 32'(dir_req), 0);
        check({tag, " z_bit"}, 32'(z_bit), 0);
        check({tag, " z_valid"}, 32'(z_valid), 0);
        check({tag, " iter"}, 32'(iter), 0);
        check({tag, " z_out"}, 32'(z_out), 0);
    endtask

    // One accumulation job. abort_iter >= 0 pulls reset a few bits into that iteration's SHIFT.
    task automatic run_job(input logic [15:0] dirs, input logic quad, input int stall_iter,
                           input int stall_len, input int abort_iter);
        int n, k, stall_cnt, nbits, pulses, busy_err, bit_err, iter_err, hold_err;
        logic [15:0] part, got_z, exp_z;
        logic seen;
        n = 0; k = 0; stall_cnt = 0; nbits = 0; pulses = 0;
        busy_err = 0; bit_err = 0; iter_err = 0; hold_err = 0;
        part = '0; got_z = '0; seen = 1'b0;
        if (abort_iter < 0) exp_q.push_back(model_z(dirs, quad, ITERS));
        start = 1'b1;
        quad_in = quad;
        @(posedge clk); #1;
        start = 1'b0;
        while (!seen && n < 3000) begin
            if (abort_iter >= 0 && busy && !dir_req && k == abort_iter + 1 && nbits == 4) begin
                rst_n = 1'b0;
                start = 1'b0;
                dir_valid = 1'b0;
                @(posedge clk); #1;
                check_all_zero("mid-shift reset");
                rst_n = 1'b1;
                return;
            end
            if (z_valid) begin
                seen = 1'b1;
                got_z = z_out;
                pulses = 1;
                start = 1'b1;
                dir_valid = 1'b0;
            end else begin
                if (!busy) busy_err++;
                if (dir_req) begin
                    if (iter !== k[3:0]) iter_err++;
                    if (k == stall_iter && stall_cnt < stall_len) begin
                        dir_valid = 1'b0;
                        dir_in = 1'($urandom);
                        stall_cnt++;
                    end else begin
                        dir_valid = 1'b1;
                        dir_in = dirs[k];
                        k++;
                        nbits = 0;
                    end
                end else begin
                    part = {z_bit, part[15:1]};
                    nbits++;
                    if (nbits == 16 && part !== model_z(dirs, quad, k)) bit_err++;
                    dir_valid = 1'($urandom);
                    dir_in = 1'($urandom);
                end
                start = ($urandom_range(0, 3) == 0);
            end
            @(posedge clk); n++; #1;
        end
        start = 1'b0;
        dir_valid = 1'b0;
        if (!seen) begin
            check("z_valid timeout", 0, 1);
            return;
        end
        exp_z = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        check("z_out", 32'(got_z), 32'(exp_z));
        check("latency", n - 1, ITERS * (WIDTH + 1) + stall_len);
        check("busy held", busy_err, 0);
        check("iter index", iter_err, 0);
        check("z_bit stream", bit_err, 0);
        for (int c = 0; c < 20; c++) begin
            if (z_valid) pulses++;
            if (z_out !== got_z) hold_err++;
            @(posedge clk); #1;
        end
        check("z_valid pulses", pulses, 1);
        check("z_out hold", hold_err, 0);
    endtask

    vec_t vecs[$];
    vec_t v;

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        start = 1'b0;
        dir_valid = 1'b0;
        dir_in = 1'b0;
        quad_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        vecs.push_back('{16'hFFFF, 1'b0, -1, 0, 16'h4706});
        vecs.push_back('{16'h5555, 1'b0, -1, 0, 16'h13BA});
        vecs.push_back('{16'h0000, 1'b0, -1, 0, 16'hB8FA});
        vecs.push_back('{16'hFFFF, 1'b0, 3, 5, 16'h4706});
`ifdef CORDIC_Z_QUAD_EN
        vecs.push_back('{16'h0000, 1'b1, -1, 0, 16'hF8FA});
`else
        vecs.push_back('{16'h0000, 1'b1, -1, 0, 16'hB8FA});
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            exp_q.push_back(v.exp_z);
            run_job(v.dirs, v.quad, v.stall_iter, v.stall_len, -1);
            // run_job queued its model value too; the table constant sits ahead of it.
            check("table vs model", 32'(v.exp_z), 32'(exp_q.pop_front()));
        end

        run_job(16'hFFFF, 1'b0, -1, 0, 7);
        @(posedge clk); #1;
        run_job(16'hFFFF, 1'b0, -1, 0, -1);

        for (int i = 0; i < 8; i++) begin
            run_job(16'($urandom), 1'($urandom), $urandom_range(0, 15), $urandom_range(0, 4), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
